wnd_reg_file: RTL
=================

# wnd_reg_file

Windowed register file for the single-cycle processor. It holds the physical register storage behind the architectural registers, and it owns the current-window pointer that the ALU control unit drives through `ldWnd` and `wndCtrl`. It sits between the instruction decode fields and the ALU operand inputs, and is written back from the ALU/data-memory result mux. Windows overlap so that a window shift passes values between adjacent windows without copying.

## Interface
- `WIDTH`, default 8: data width of every register.
- `NPHYS`, default 8: physical register count. Fixed at 8 for this revision; other values are unsupported.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `regWrite` input, 1 bit: write enable for the write port.
- `ldWnd` input, 1 bit: window-pointer update enable.
- `wndCtrl` input, 2 bits: window operation, sampled when `ldWnd`=1.
- `rdAddr1` input, 2 bits: architectural read address, port 1.
- `rdAddr2` input, 2 bits: architectural read address, port 2.
- `wrAddr` input, 2 bits: architectural write address.
- `wrData` input, WIDTH bits: write data.
- `rdData1` output, WIDTH bits: read data, port 1 (combinational).
- `rdData2` output, WIDTH bits: read data, port 2 (combinational).
- `wnd` output, 2 bits: current window pointer (WP), registered.

## Operation
- **Storage**
  - 8 physical registers `P[0..7]`, each WIDTH bits.
  - 4 windows, each 4 architectural registers `r0..r3`.
- **Mapping**
  - Architectural register `i` in window `w` maps to physical index `(2*w + i) mod 8`.
  - The two highest registers of window `w` (r2, r3) alias the two lowest (r0, r1) of window `w+1`.
  - Window 3's r2/r3 wrap to `P[0]`/`P[1]`.
- **Reads**
  - `rdDataN = P[(2*WP + rdAddrN) mod 8]`, purely combinational from the current WP and storage.
  - Both ports are independent, and both may address the same register.
- **Write**
  - On a rising edge with `regWrite`=1, `P[(2*WP + wrAddr) mod 8] <= wrData`.
  - WP is the value before any same-edge window update.
- **Window pointer**, on a rising edge with `ldWnd`=1:
  - `wndCtrl`=00: hold.
  - `wndCtrl`=01: WP <= WP+1 mod 4 (3 wraps to 0).
  - `wndCtrl`=10: WP <= WP-1 mod 4 (0 wraps to 3).
  - `wndCtrl`=11: WP <= 0.
  - `ldWnd`=0: WP holds regardless of `wndCtrl`.
- **Reset**
  - `rst`=0 immediately clears all `P[*]` to 0 and WP to 0, independent of `clk`.
  - Outputs during reset: `wnd`=0, `rdData1`=`rdData2`=0.
  - While `rst`=0, writes and window updates are ignored.
  - Reset asserted mid-operation discards any pending edge effect.
- There is no overflow/underflow trap and no spill/fill. Wrap-around is silent, and the data in reused physical registers is overwritten by later writes.

## Timing
- **Read latency:** zero cycles, combinational. A write on edge N is visible on the read ports after edge N; there is no write-to-read bypass within the same cycle.
- **Write latency:** one edge.
- **Window update latency:** one edge. Reads in the cycle after the update use the new WP.
- **Simultaneous write and `ldWnd` on the same edge:** the write targets the old window, and WP changes on that same edge.
- **Reset release:** the first effective edge is the first rising edge with `rst`=1. Deassertion must meet recovery time relative to `clk`; it is not synchronized internally.
- **Paths:** no combinational path from `wrData`/`regWrite`/`ldWnd` to the outputs. `rdData*` depend only on the read addresses, WP and storage.

## Test plan
- **Reset:** hold `rst`=0 mid-run after writes.
  - Required: `wnd`=0 and both read ports return 0 for every address, before any clock edge.
- **Basic write/read:** in WP=0, write r1=0x5A.
  - Required: after the edge, `rdAddr1`=1 gives `rdData1`=0x5A.
  - Same-cycle read before the edge gives the old value, 0.
- **Overlap:** in WP=0, write r2=0x11 and r3=0x22. Then `ldWnd`=1, `wndCtrl`=01.
  - Required: `wnd`=1; r0 reads 0x11 and r1 reads 0x22.
- **Wrap:** from WP=3, increment.
  - Required: WP=0.
  - From WP=0, decrement: WP=3.
  - In WP=3, writing r2=0x77 makes r0 read 0x77 in WP=0.
- **Simultaneous events:** in WP=1, `regWrite`=1 with `wrAddr`=0, `wrData`=0xC3, and `ldWnd`=1 with `wndCtrl`=01, all on the same edge.
  - Required: `P[2]`=0xC3 and `wnd`=2.
  - Decrement back to WP=1: r0 reads 0xC3.
- **Hold/clear:** `ldWnd`=0 with `wndCtrl`=01 for 3 edges leaves WP unchanged. `ldWnd`=1 with `wndCtrl`=11 from WP=2 gives WP=0, and register contents are preserved.

Source files
------------

// File: rtl/wnd_reg_file.sv
// wnd_reg_file: 8-entry register file seen through four overlapping 4-register windows
module wnd_reg_file #(
    parameter int WIDTH = 8,
    parameter int NPHYS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             regWrite,
    input  logic             ldWnd,
    input  logic [1:0]       wndCtrl,
    input  logic [1:0]       rdAddr1,
    input  logic [1:0]       rdAddr2,
    input  logic [1:0]       wrAddr,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] rdData1,
    output logic [WIDTH-1:0] rdData2,
    output logic [1:0]       wnd
);
    logic [WIDTH-1:0] r_p [0:NPHYS-1];
    logic [1:0]       r_wp;
    logic [2:0]       w_base;
    logic [2:0]       w_wr_idx;
    logic [2:0]       w_rd1_idx;
    logic [2:0]       w_rd2_idx;
    logic [1:0]       w_wp_nxt;

    // Window w starts at physical 2*w; the 3-bit sum wraps mod 8 so window 3 overlaps window 0
    always_comb begin
        w_base    = {r_wp, 1'b0};
        w_wr_idx  = w_base + {1'b0, wrAddr};
        w_rd1_idx = w_base + {1'b0, rdAddr1};
        w_rd2_idx = w_base + {1'b0, rdAddr2};
        w_wp_nxt  = (wndCtrl == 2'b01) ? r_wp + 2'd1 :
                    (wndCtrl == 2'b10) ? r_wp - 2'd1 :
                    (wndCtrl == 2'b11) ? 2'd0 : r_wp;
    end

    // Storage and window pointer; the write uses the pre-update window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NPHYS; i++) r_p[i] <= '0;
            r_wp <= 2'd0;
        end else begin
            if (regWrite) r_p[w_wr_idx] <= wrData;
            if (ldWnd) r_wp <= w_wp_nxt;
        end
    end

    assign rdData1 = r_p[w_rd1_idx];
    assign rdData2 = r_p[w_rd2_idx];
    assign wnd     = r_wp;
endmodule
